// File: rtl/ucie_ctl_rx_credit_ctrl_if.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_credit_ctrl_if
//
// Bundles the link-state, RX-buffer and credit-return signals of the UCIe
// controller RX credit controller.
//
// Signals (direction seen from the credit controller):
//   i_state_request        in   link-state request, 1 = RX path active
//   i_flit_valid           in   one flit written into the RX buffer
//   i_flit_consumed        in   one flit read out by the protocol layer
//   i_overflow_detected    in   overflow flag raised by the RX buffer
//   i_credit_return_ready  in   credit return path accepts the transfer
//   o_buffer_enable        out  RX buffer write enable
//   o_credit_return_valid  out  credit return transfer pending
//   o_credit_return_count  out  credits carried by the transfer
//   o_overflow_detected    out  sticky overflow / error flag
//   o_occupancy            out  current RX buffer occupancy
//   o_state                out  controller state (00 IDLE, 01 ACTIVE,
//                               10 DRAIN, 11 ERROR)
//
// Credit return handshake: a transfer is offered by raising
// o_credit_return_valid together with o_credit_return_count. Both hold
// stable until a rising clock edge sees valid and i_credit_return_ready
// high together; that edge completes the transfer and valid drops for at
// least one cycle before another transfer is offered. ready may be high
// while valid is low without effect. The one exception is entry to ERROR,
// which withdraws an outstanding offer and abandons it.
//
// Modports: slave = the credit controller, master = the surrounding logic
// (or a testbench) driving the requests and observing the results.
// ---------------------------------------------------------------------------
interface ucie_ctl_rx_credit_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             i_state_request;
  logic             i_flit_valid;
  logic             i_flit_consumed;
  logic             i_overflow_detected;
  logic             i_credit_return_ready;
  logic             o_buffer_enable;
  logic             o_credit_return_valid;
  logic [CNT_W-1:0] o_credit_return_count;
  logic             o_overflow_detected;
  logic [CNT_W-1:0] o_occupancy;
  logic [1:0]       o_state;

  modport master (
    output i_state_request,
    output i_flit_valid,
    output i_flit_consumed,
    output i_overflow_detected,
    output i_credit_return_ready,
    input  o_buffer_enable,
    input  o_credit_return_valid,
    input  o_credit_return_count,
    input  o_overflow_detected,
    input  o_occupancy,
    input  o_state
  );

  modport slave (
    input  i_state_request,
    input  i_flit_valid,
    input  i_flit_consumed,
    input  i_overflow_detected,
    input  i_credit_return_ready,
    output o_buffer_enable,
    output o_credit_return_valid,
    output o_credit_return_count,
    output o_overflow_detected,
    output o_occupancy,
    output o_state
  );
endinterface

// File: rtl/ucie_ctl_rx_credit_ctrl.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_credit_ctrl
//
// Sequences the UCIe controller RX buffer and returns flow-control credits
// to the remote transmitter. Buffer occupancy is tracked from the write and
// consume strobes, the buffer is only write-enabled in ACTIVE, and freed
// entries are batched into credit-return transfers. Any overflow (local
// accounting or reported by the buffer) latches the block into ERROR until
// reset.
//
// Ports:
//   i_clk  block clock, rising edge
//   i_rst  asynchronous active-high reset; all outputs read 0 while high
//   bus    ucie_ctl_rx_credit_ctrl_if.slave (requests in, status out)
//
// All outputs come straight from registers. o_state doubles as the FSM
// debug view: 00 IDLE, 01 ACTIVE, 10 DRAIN, 11 ERROR.
//
// Optional build macro UCIE_CTL_RX_CREDIT_TIMEOUT_EN: when defined, a
// partial batch (0 < pending < CREDIT_BATCH) that sits unchanged in ACTIVE
// for TIMEOUT_CYCLES cycles is flushed as one transfer of all pending
// credits. When undefined, ACTIVE only returns full batches and partial
// batches wait for DRAIN.
// ---------------------------------------------------------------------------
module ucie_ctl_rx_credit_ctrl #(
  parameter int BUF_DEPTH      = 16,
  parameter int CNT_W          = 5,
  parameter int CREDIT_BATCH   = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic                    i_clk,
  input logic                    i_rst,
  ucie_ctl_rx_credit_ctrl_if.slave bus
);

  // Elaboration-time sanity checks on the configuration.
  if (CNT_W < $clog2(BUF_DEPTH + 1)) begin : g_bad_cnt_w
    $error("CNT_W too small for BUF_DEPTH");
  end
  if (CREDIT_BATCH < 1 || CREDIT_BATCH > BUF_DEPTH) begin : g_bad_batch
    $error("CREDIT_BATCH out of range 1..BUF_DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(CREDIT_BATCH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] pend;
  logic             ret_valid;
  logic [CNT_W-1:0] ret_count;
  logic             buf_en;
  logic             ovf;

`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;
`endif

  // Next-value helpers, only consumed in ACTIVE / DRAIN.
  logic             in_flow;
  logic             overflow_hit;
  logic             accept_consume;
  logic             handshake;
  logic             timeout_fire;
  logic             issue;
  logic [CNT_W-1:0] issue_count;
  logic             valid_next;
  logic [CNT_W-1:0] occ_next;
  logic [CNT_W-1:0] pend_next;

`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
  assign timeout_fire = (state == ST_ACTIVE) && !ret_valid && (pend != '0) &&
                        (pend < BATCH_C) && (tmr == TMR_W'(TIMEOUT_CYCLES));
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    in_flow        = (state == ST_ACTIVE) || (state == ST_DRAIN);
    // A write with a simultaneous consume does not grow occupancy, so only
    // an unmatched write into a full buffer counts as local overflow.
    overflow_hit   = in_flow &&
                     ((bus.i_flit_valid && !bus.i_flit_consumed && (occ == DEPTH_C)) ||
                      bus.i_overflow_detected);
    accept_consume = bus.i_flit_consumed && (occ != '0);
    handshake      = ret_valid && bus.i_credit_return_ready;

    // A new offer is decided from the registered pending count; in DRAIN
    // any nonzero remainder goes out regardless of batch size.
    issue       = 1'b0;
    issue_count = '0;
    if (!ret_valid) begin
      if ((state == ST_ACTIVE) && (pend >= BATCH_C)) begin
        issue       = 1'b1;
        issue_count = BATCH_C;
      end else if ((state == ST_DRAIN) && (pend != '0)) begin
        issue       = 1'b1;
        issue_count = pend;
      end else if (timeout_fire) begin
        issue       = 1'b1;
        issue_count = pend;
      end
    end

    // Completing a transfer always forces a low cycle on valid.
    valid_next = handshake ? 1'b0 : (ret_valid || issue);

    occ_next  = occ + CNT_W'(bus.i_flit_valid) - CNT_W'(accept_consume);
    pend_next = pend - (handshake ? ret_count : '0) + CNT_W'(accept_consume);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      occ       <= '0;
      pend      <= '0;
      ret_valid <= 1'b0;
      ret_count <= '0;
      buf_en    <= 1'b0;
      ovf       <= 1'b0;
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
      tmr       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_state_request) begin
            state  <= ST_ACTIVE;
            buf_en <= 1'b1;
          end
        end

        ST_ACTIVE, ST_DRAIN: begin
          if (overflow_hit) begin
            // Counters freeze as they are; any outstanding offer is dropped.
            state     <= ST_ERROR;
            buf_en    <= 1'b0;
            ovf       <= 1'b1;
            ret_valid <= 1'b0;
            ret_count <= '0;
          end else begin
            occ       <= occ_next;
            pend      <= pend_next;
            ret_valid <= valid_next;
            if (issue) begin
              ret_count <= issue_count;
            end else if (!valid_next) begin
              ret_count <= '0;
            end

`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
            // Count only while a partial batch sits unchanged with nothing
            // in flight; any movement of pending restarts the wait.
            if ((state == ST_ACTIVE) && !ret_valid && !issue && (pend != '0) &&
                (pend < BATCH_C) && (pend_next == pend)) begin
              tmr <= tmr + 1'b1;
            end else begin
              tmr <= '0;
            end
`endif

            if ((state == ST_ACTIVE) && !bus.i_state_request) begin
              state  <= ST_DRAIN;
              buf_en <= 1'b0;
            end else if ((state == ST_DRAIN) && bus.i_state_request) begin
              state  <= ST_ACTIVE;
              buf_en <= 1'b1;
            end else if ((state == ST_DRAIN) && (occ_next == '0) &&
                         (pend_next == '0) && !valid_next) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_ERROR: begin
          // Terminal until reset.
        end
      endcase
    end
  end

  assign bus.o_buffer_enable       = buf_en;
  assign bus.o_credit_return_valid = ret_valid;
  assign bus.o_credit_return_count = ret_count;
  assign bus.o_overflow_detected   = ovf;
  assign bus.o_occupancy           = occ;
  assign bus.o_state               = state;

endmodule

// File: tb/tb_ucie_ctl_rx_credit_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ucie_ctl_rx_credit_ctrl. A transaction-level model tracks
// occupancy, pending credits and the offered transfer; an expected queue
// holds the credit counts each completed handshake must carry.
// ---------------------------------------------------------------------------
module tb_ucie_ctl_rx_credit_ctrl;
  localparam int BUF_DEPTH      = 16;
  localparam int CNT_W          = 5;
  localparam int CREDIT_BATCH   = 4;
  localparam int TIMEOUT_CYCLES = 32;

  localparam int S_IDLE  = 0;
  localparam int S_ACT   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_ERR   = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ucie_ctl_rx_credit_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ucie_ctl_rx_credit_ctrl #(
    .BUF_DEPTH     (BUF_DEPTH),
    .CNT_W         (CNT_W),
    .CREDIT_BATCH  (CREDIT_BATCH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model
  int m_state, m_occ, m_pend, m_count, m_tmr;
  bit m_valid, m_en, m_ovf;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_occ = 0; m_pend = 0; m_count = 0; m_tmr = 0;
    m_valid = 0; m_en = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic offer(input int cnt);
    m_valid = 1;
    m_count = cnt;
    exp_q.push_back(CNT_W'(cnt));
  endtask

  // One clock of the specification's rules applied to the model.
  task automatic model_step(input bit sr, input bit fv, input bit fc, input bit ov, input bit rdy);
    bit acc;
    bit was_valid;
    bit offered;
    int pend0;
    if (m_state == S_IDLE) begin
      if (sr) begin m_state = S_ACT; m_en = 1; end
      return;
    end
    if (m_state == S_ERR) return;
    if (ov || (fv && !fc && m_occ == BUF_DEPTH)) begin
      m_state = S_ERR; m_en = 0; m_ovf = 1; m_valid = 0; m_count = 0;
      exp_q.delete();
      return;
    end
    acc       = fc && (m_occ > 0);
    pend0     = m_pend;
    was_valid = m_valid;
    offered   = 0;
    if (m_valid) begin
      if (rdy) begin m_pend -= m_count; m_valid = 0; m_count = 0; end
    end else if (m_state == S_ACT && pend0 >= CREDIT_BATCH) begin
      offer(CREDIT_BATCH); offered = 1;
    end else if (m_state == S_DRAIN && pend0 > 0) begin
      offer(pend0); offered = 1;
    end
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
    else if (m_state == S_ACT && m_tmr == TIMEOUT_CYCLES && pend0 > 0) begin
      offer(pend0); offered = 1;
    end
`endif
    m_occ  = m_occ + int'(fv) - int'(acc);
    m_pend = m_pend + int'(acc);
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
    if (m_state == S_ACT && !was_valid && !offered && pend0 > 0 &&
        pend0 < CREDIT_BATCH && m_pend == pend0) m_tmr++;
    else m_tmr = 0;
`else
    if (offered && was_valid) m_tmr = 0;
`endif
    if (m_state == S_ACT && !sr) begin
      m_state = S_DRAIN; m_en = 0;
    end else if (m_state == S_DRAIN && sr) begin
      m_state = S_ACT; m_en = 1;
    end else if (m_state == S_DRAIN && m_occ == 0 && m_pend == 0 && !m_valid) begin
      m_state = S_IDLE;
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".state"}, 32'(bus.o_state), 32'(m_state));
    check({ph, ".buf_en"}, 32'(bus.o_buffer_enable), 32'(m_en));
    check({ph, ".valid"}, 32'(bus.o_credit_return_valid), 32'(m_valid));
    check({ph, ".count"}, 32'(bus.o_credit_return_count), 32'(m_count));
    check({ph, ".ovf"}, 32'(bus.o_overflow_detected), 32'(m_ovf));
    check({ph, ".occ"}, 32'(bus.o_occupancy), 32'(m_occ));
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, ".state"}, 32'(bus.o_state), 32'd0);
    check({ph, ".buf_en"}, 32'(bus.o_buffer_enable), 32'd0);
    check({ph, ".valid"}, 32'(bus.o_credit_return_valid), 32'd0);
    check({ph, ".count"}, 32'(bus.o_credit_return_count), 32'd0);
    check({ph, ".ovf"}, 32'(bus.o_overflow_detected), 32'd0);
    check({ph, ".occ"}, 32'(bus.o_occupancy), 32'd0);
  endtask

  // driver: apply inputs for one cycle, score any handshake, advance model
  task automatic step(input string ph, input bit sr, input bit fv, input bit fc,
                      input bit ov, input bit rdy);
    logic [CNT_W-1:0] want;
    bus.i_state_request       = sr;
    bus.i_flit_valid          = fv;
    bus.i_flit_consumed       = fc;
    bus.i_overflow_detected   = ov;
    bus.i_credit_return_ready = rdy;
    if (bus.o_credit_return_valid === 1'b1 && rdy) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({ph, ".xfer"}, 32'(bus.o_credit_return_count), 32'(want));
    end
    @(posedge clk);
    model_step(sr, fv, fc, ov, rdy);
    #1;
    check_outputs(ph);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit sr;
    bus.i_state_request       = 1'b0;
    bus.i_flit_valid          = 1'b0;
    bus.i_flit_consumed       = 1'b0;
    bus.i_overflow_detected   = 1'b0;
    bus.i_credit_return_ready = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset();

    // IDLE ignores flits and external overflow
    step("idle_ign", 0, 1, 0, 1, 1);
    step("idle_ign", 0, 0, 1, 0, 1);

    // activate
    step("activate", 1, 0, 0, 0, 0);

    // 6 writes, 4 consumes with ready high: one batch of 4, occupancy 2
    repeat (6) step("wr6", 1, 1, 0, 0, 1);
    repeat (4) step("cons4", 1, 0, 1, 0, 1);
    repeat (3) step("batch4", 1, 0, 0, 0, 1);

    // refill, 5 consumes with ready low, hold 3 more cycles, then accept
    repeat (5) step("wr5", 1, 1, 0, 0, 0);
    repeat (5) step("cons5", 1, 0, 1, 0, 0);
    repeat (3) step("hold", 1, 0, 0, 0, 0);
    repeat (3) step("accept", 1, 0, 0, 0, 1);

    // simultaneous write and consume leave occupancy unchanged
    step("wr_cons", 1, 1, 1, 0, 1);

    // partial batch stays put in ACTIVE (flushed only by the timeout build)
    repeat (40) step("partial", 1, 0, 0, 0, 1);

    // randomized traffic, including ACTIVE/DRAIN/IDLE excursions
    sr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit fv, fc, rdy;
      if ($urandom_range(0, 99) < 4) sr = ~sr;
      fv  = ($urandom_range(0, 99) < 45) && (m_occ < BUF_DEPTH);
      fc  = ($urandom_range(0, 99) < 45);
      rdy = ($urandom_range(0, 99) < 60);
      step("rand", sr, fv, fc, 1'b0, rdy);
    end

    // drain everything back to IDLE (bounded on the model)
    for (int i = 0; i < 100 && m_state != S_IDLE; i++) step("flush", 0, 0, 1, 0, 1);
    check("flush.idle", 32'(bus.o_state), 32'(S_IDLE));

    // occupancy 2, drop request, consume 2 -> DRAIN return of 2, then IDLE
    step("act2", 1, 0, 0, 0, 1);
    repeat (2) step("wr2", 1, 1, 0, 0, 1);
    repeat (2) step("drain_cons", 0, 0, 1, 0, 1);
    repeat (4) step("drain_ret", 0, 0, 0, 0, 1);
    check("drain.idle", 32'(bus.o_state), 32'(S_IDLE));

    // fill, leave a transfer outstanding, refill, then overflow
    step("act3", 1, 0, 0, 0, 0);
    repeat (16) step("fill16", 1, 1, 0, 0, 0);
    repeat (4) step("cons_nr", 1, 0, 1, 0, 0);
    repeat (4) step("refill", 1, 1, 0, 0, 0);
    step("ovf17", 1, 1, 0, 0, 0);
    check("ovf.occ", 32'(bus.o_occupancy), 32'(BUF_DEPTH));
    for (int i = 0; i < 10; i++)
      step("err_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // asynchronous reset mid-cycle clears outputs at once
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    release_reset();

    // external overflow while ACTIVE
    step("act4", 1, 0, 0, 0, 0);
    repeat (3) step("wr3", 1, 1, 0, 0, 0);
    step("ext_ovf", 1, 0, 1, 1, 1);
    repeat (3) step("ext_hold", 0, 0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ucie_ctl_rx_credit_ctrl.md
Name: ucie_ctl_rx_credit_ctrl

Overview:
Sequences the UCIe controller RX buffer and manages flow-control credits back to the remote transmitter. It tracks buffer occupancy from write and consume strobes, enables the buffer only while the link state requests it, and batches freed entries into credit-return transfers over a valid/ready handshake. Overflow from either local accounting or the buffer itself is latched as a fatal error. The block sits between the link-state logic, the RX buffer and the TX-side credit return path.

Parameters:
BUF_DEPTH, 16, number of RX buffer entries; equals initial remote credits.
CNT_W, 5, counter width; must be at least $clog2(BUF_DEPTH+1).
CREDIT_BATCH, 4, freed entries accumulated before a credit return in ACTIVE; range 1..BUF_DEPTH.
TIMEOUT_CYCLES, 32, idle-flush timeout; used only with the optional feature.

Ports:
i_clk  input  1  block clock, rising edge.
i_rst  input  1  asynchronous active-high reset.
i_state_request  input  1  link-state request: 1 = RX path active.
i_flit_valid  input  1  one flit written into the RX buffer this cycle.
i_flit_consumed  input  1  one flit read out by the protocol layer this cycle.
i_overflow_detected  input  1  overflow flag from the RX buffer.
i_credit_return_ready  input  1  credit return path accepts the transfer.
o_buffer_enable  output  1  RX buffer write enable.
o_credit_return_valid  output  1  credit return transfer pending.
o_credit_return_count  output  CNT_W  credits carried by the transfer.
o_overflow_detected  output  1  sticky overflow or error flag.
o_occupancy  output  CNT_W  current buffer occupancy.
o_state  output  2  FSM state: 00 IDLE, 01 ACTIVE, 10 DRAIN, 11 ERROR.

Behaviour:
- The reset value of every output is 0; the FSM resets to IDLE; the internal pending-credit counter resets to 0.
- All outputs are registered. A change in an input becomes visible on the outputs on the next rising edge.
- IDLE:
  - o_buffer_enable=0. i_flit_valid and i_flit_consumed are ignored.
  - i_state_request=1 moves the FSM to ACTIVE. o_buffer_enable=1 from that edge.
- ACTIVE:
  - Occupancy update: +1 on i_flit_valid, -1 on i_flit_consumed. Both asserted in the same cycle leaves occupancy unchanged.
  - i_flit_consumed with occupancy 0 is ignored and does not add a credit.
  - Each accepted consume increments the pending-credit counter.
  - With no transfer outstanding and pending >= CREDIT_BATCH: assert o_credit_return_valid with o_credit_return_count=CREDIT_BATCH.
  - o_credit_return_valid and o_credit_return_count hold stable until i_credit_return_ready=1.
  - On valid&ready, pending decreases by the transferred count. A consume in the same cycle still adds +1 to the new value. o_credit_return_valid drops for at least one cycle before the next transfer.
  - i_state_request=0 moves the FSM to DRAIN.
- DRAIN:
  - o_buffer_enable=0. Consume accounting continues.
  - Any nonzero pending is returned regardless of CREDIT_BATCH, with count = pending sampled when valid rises.
  - An i_flit_valid still arriving in DRAIN is counted, covering in-flight flits.
  - Return to IDLE when occupancy=0, pending=0 and no transfer is outstanding.
  - i_state_request=1 moves the FSM back to ACTIVE without clearing counters.
- Overflow:
  - Local overflow: i_flit_valid without i_flit_consumed while occupancy=BUF_DEPTH, in ACTIVE or DRAIN.
  - External overflow: i_overflow_detected=1 in any state other than IDLE.
  - Either one moves the FSM to ERROR next edge. Occupancy is not incremented past BUF_DEPTH.
- ERROR:
  - o_buffer_enable=0 and o_overflow_detected=1.
  - o_credit_return_valid=0 immediately, even if a handshake was outstanding; that transfer is abandoned.
  - Counters are frozen. The only exit is i_rst.
- Reset asserted mid-operation clears everything asynchronously. Outputs read 0 while i_rst=1.

Optional Feature:
UCIE_CTL_RX_CREDIT_TIMEOUT_EN:
- Defined: in ACTIVE, a cycle counter runs while 0 < pending < CREDIT_BATCH and no transfer is outstanding. The counter clears on any change of pending. When it reaches TIMEOUT_CYCLES, a transfer of all pending credits is issued.
- Not defined: in ACTIVE, credits return only at the CREDIT_BATCH threshold. Partial batches wait for DRAIN.

Test Plan:
- Reset, then i_state_request=1 -> o_state=01 and o_buffer_enable=1 one edge later. All outputs are 0 during reset.
- 6 writes, then 4 consumes, ready held at 1 -> o_credit_return_valid pulses with count=4; occupancy ends at 2; pending=0.
- 16 writes without consume, then a 17th write -> o_state=11, o_overflow_detected=1, o_buffer_enable=0, occupancy=16. This persists until i_rst.
- 5 consumes with ready=0 for 3 cycles -> valid held with count=4 throughout. After ready, pending=1 and valid low for at least one cycle.
- With occupancy 2, drop i_state_request, consume 2, ready=1 -> DRAIN return of count=2, then o_state=00.
- Macro defined, 2 consumes, then idle -> transfer with count=2 after 32 cycles. Macro undefined -> no transfer.
